// File: rtl/reg_arb_pkg.sv
// Shared types and helpers for the round-robin register write arbiter.
package reg_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Index width for n requesters; never below 1 so a port always exists.
    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

    function automatic int be_width(input int dw);
        return dw / 8;
    endfunction

endpackage

// File: rtl/reg_write_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid requester after ptr, wrapping.
module rr_pick
    import reg_arb_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDW  = clog2(NREQ)
) (
    input  logic [NREQ-1:0] valid_i,
    input  logic [IDW-1:0]  ptr_i,
    output logic [NREQ-1:0] grant_o,
    output logic [IDW-1:0]  idx_o,
    output logic            any_o
);

    int             cand;
    logic [IDW-1:0] cand_idx;

    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves a latch.
        grant_o  = '0;
        idx_o    = '0;
        any_o    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand     = (int'(ptr_i) + k) % NREQ;
            cand_idx = IDW'(cand);
            if (!any_o && valid_i[cand_idx]) begin
                grant_o[cand_idx] = 1'b1;
                idx_o             = cand_idx;
                any_o             = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin sequencer sharing one byte-enabled register among NREQ writers.
// Optional REG_ARB_LOCK_EN: a locked grant keeps priority with the same requester.
module reg_write_arbiter
    import reg_arb_pkg::*;
#(
    parameter  int NREQ = 2,
    parameter  int DW   = 16,
    parameter  int CNTW = 8,
    localparam int BE_W = be_width(DW),
    localparam int IDW  = clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*DW-1:0]   req_data,
    input  logic [NREQ*BE_W-1:0] req_be,
    input  logic [NREQ-1:0]      req_lock,
    output logic [NREQ-1:0]      req_ready,
    output logic [DW-1:0]        reg_d,
    output logic [BE_W-1:0]      reg_ena,
    output logic                 wr_done,
    output logic [IDW-1:0]       wr_id,
    output logic [CNTW-1:0]      wr_count
);

    state_e          state_q, state_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [IDW-1:0]  id_q, id_d;
    logic [BE_W-1:0] be_q, be_d;
    logic [DW-1:0]   reg_d_q, reg_d_d;
    logic [BE_W-1:0] reg_ena_q, reg_ena_d;
    logic            wr_done_q, wr_done_d;
    logic [IDW-1:0]  wr_id_q, wr_id_d;
    logic [CNTW-1:0] wr_count_q, wr_count_d;

    logic [NREQ-1:0] pick_grant;
    logic [IDW-1:0]  pick_idx;
    logic            pick_any;

`ifdef REG_ARB_LOCK_EN
    logic            lock_q, lock_d;
`else
    logic            unused_lock;
    assign unused_lock = ^req_lock;
`endif

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .valid_i (req_valid),
        .ptr_i   (ptr_q),
        .grant_o (pick_grant),
        .idx_o   (pick_idx),
        .any_o   (pick_any)
    );

    // Ready is masked while reset is low so nothing looks accepted during reset.
    assign req_ready = (state_q == IDLE && reset) ? pick_grant : '0;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        id_d       = id_q;
        be_d       = be_q;
        reg_d_d    = reg_d_q;
        reg_ena_d  = '0;
        wr_done_d  = 1'b0;
        wr_id_d    = wr_id_q;
        wr_count_d = wr_count_q;
`ifdef REG_ARB_LOCK_EN
        lock_d     = lock_q;
`endif
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    id_d      = pick_idx;
                    be_d      = req_be[pick_idx*BE_W +: BE_W];
                    reg_d_d   = req_data[pick_idx*DW +: DW];
                    reg_ena_d = req_be[pick_idx*BE_W +: BE_W];
`ifdef REG_ARB_LOCK_EN
                    lock_d    = req_lock[pick_idx];
`endif
                    state_d   = WRITE;
                end
            end
            WRITE: begin
`ifdef REG_ARB_LOCK_EN
                // Parking ptr one below id makes id the first candidate next time.
                if (lock_q) begin
                    ptr_d = (id_q == '0) ? IDW'(NREQ - 1) : id_q - 1'b1;
                end else begin
                    ptr_d = id_q;
                end
`else
                ptr_d = id_q;
`endif
                wr_done_d = 1'b1;
                wr_id_d   = id_q;
                if (be_q != '0) begin
                    wr_count_d = wr_count_q + 1'b1;
                end
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            ptr_q      <= IDW'(NREQ - 1);
            id_q       <= '0;
            be_q       <= '0;
            reg_d_q    <= '0;
            reg_ena_q  <= '0;
            wr_done_q  <= 1'b0;
            wr_id_q    <= '0;
            wr_count_q <= '0;
`ifdef REG_ARB_LOCK_EN
            lock_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            id_q       <= id_d;
            be_q       <= be_d;
            reg_d_q    <= reg_d_d;
            reg_ena_q  <= reg_ena_d;
            wr_done_q  <= wr_done_d;
            wr_id_q    <= wr_id_d;
            wr_count_q <= wr_count_d;
`ifdef REG_ARB_LOCK_EN
            lock_q     <= lock_d;
`endif
        end
    end

    assign reg_d    = reg_d_q;
    assign reg_ena  = reg_ena_q;
    assign wr_done  = wr_done_q;
    assign wr_id    = wr_id_q;
    assign wr_count = wr_count_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Randomized and directed bench for reg_write_arbiter against a cycle-indexed event model.
module tb_reg_write_arbiter;

    localparam int NREQ = 2;
    localparam int DW   = 16;
    localparam int CNTW = 8;
    localparam int BE_W = DW / 8;
    localparam int IDW  = 1;

    logic                 clk;
    logic                 reset;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*DW-1:0]   req_data;
    logic [NREQ*BE_W-1:0] req_be;
    logic [NREQ-1:0]      req_lock;
    logic [NREQ-1:0]      req_ready;
    logic [DW-1:0]        reg_d;
    logic [BE_W-1:0]      reg_ena;
    logic                 wr_done;
    logic [IDW-1:0]       wr_id;
    logic [CNTW-1:0]      wr_count;

    reg_write_arbiter #(
        .NREQ (NREQ),
        .DW   (DW),
        .CNTW (CNTW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_be    (req_be),
        .req_lock  (req_lock),
        .req_ready (req_ready),
        .reg_d     (reg_d),
        .reg_ena   (reg_ena),
        .wr_done   (wr_done),
        .wr_id     (wr_id),
        .wr_count  (wr_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Model: acceptance in cycle N schedules an enable in N+1 and a completion in N+2;
    // 'first' is the requester that has priority in the next arbitration.
    int              cyc       = 0;
    int              write_cyc = -1;
    int              done_cyc  = -1;
    int              first     = 0;
    int              pend_id   = 0;
    logic [DW-1:0]   pend_data = '0;
    logic [BE_W-1:0] pend_be   = '0;
    logic [DW-1:0]   exp_regd  = '0;
    logic [IDW-1:0]  exp_wrid  = '0;
    logic [CNTW-1:0] exp_count = '0;
    bit              checking  = 0;
    int              grants[$];
    int              grant_cyc[$];

    task automatic step();
        logic [NREQ-1:0] exp_ready;
        int              win;
        bit              lk;
        #1;
        if (cyc == write_cyc) exp_regd = pend_data;
        if (cyc == done_cyc) begin
            exp_wrid = IDW'(pend_id);
            if (pend_be != '0) exp_count++;
        end
        exp_ready = '0;
        win = -1;
        if (reset && cyc > done_cyc) begin
            for (int k = 0; k < NREQ; k++) begin
                int c;
                c = (first + k) % NREQ;
                if (win < 0 && req_valid[c]) win = c;
            end
        end
        if (win >= 0) exp_ready[win] = 1'b1;
        if (checking) begin
            check("ready", req_ready, exp_ready);
            check("reg_ena", reg_ena, (cyc == write_cyc) ? pend_be : {BE_W{1'b0}});
            check("reg_d", reg_d, exp_regd);
            check("wr_done", wr_done, cyc == done_cyc);
            if (cyc == done_cyc) check("wr_id", wr_id, exp_wrid);
            check("wr_count", wr_count, exp_count);
        end
        @(posedge clk);
        if (!reset) begin
            write_cyc = -1;
            done_cyc  = -1;
            first     = 0;
            exp_regd  = '0;
            exp_wrid  = '0;
            exp_count = '0;
        end else if (win >= 0) begin
            pend_id   = win;
            pend_data = req_data[win*DW +: DW];
            pend_be   = req_be[win*BE_W +: BE_W];
            write_cyc = cyc + 1;
            done_cyc  = cyc + 2;
            lk        = req_lock[win];
`ifdef REG_ARB_LOCK_EN
            first = lk ? win : (win + 1) % NREQ;
`else
            first = (win + 1) % NREQ;
`endif
            grants.push_back(win);
            grant_cyc.push_back(cyc);
        end
        checking = 1;
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
    endtask

    int              base;
    logic [CNTW-1:0] cnt_before;
    int              exp6[4];

    initial begin
        reset     = 1'b0;
        req_valid = '1;
        req_data  = '0;
        req_be    = '1;
        req_lock  = '0;
        @(negedge clk);

        // Reset held with all requesters valid.
        step();
        #1;
        check("t1_ready", req_ready, 0);
        check("t1_reg_ena", reg_ena, 0);
        check("t1_wr_count", wr_count, 0);
        check("t1_wr_done", wr_done, 0);
        step();
        reset = 1'b1;

        // Single write from requester 0.
        req_valid = 2'b01;
        req_data  = {16'h0000, 16'hA55A};
        req_be    = {2'b00, 2'b11};
        #1;
        check("t2_ready", req_ready, 2'b01);
        step();
        req_valid = '0;
        #1;
        check("t2_reg_d", reg_d, 16'hA55A);
        check("t2_reg_ena", reg_ena, 2'b11);
        step();
        #1;
        check("t2_wr_done", wr_done, 1);
        check("t2_wr_id", wr_id, 0);
        check("t2_wr_count", wr_count, 1);
        step();

        // Contention: both valid continuously.
        do_reset();
        base      = grants.size();
        req_valid = 2'b11;
        req_data  = {16'h1111, 16'h2222};
        req_be    = 4'b1111;
        for (int i = 0; i < 40 && grants.size() < base + 4; i++) step();
        check("t3_grant_count", grants.size(), base + 4);
        if (grants.size() >= base + 4) begin
            for (int i = 0; i < 4; i++) begin
                check("t3_grant_order", grants[base+i], i % 2);
                if (i > 0) check("t3_spacing", grant_cyc[base+i] - grant_cyc[base+i-1], 3);
            end
        end
        req_valid = '0;
        step();
        step();

        // Empty byte enable from requester 1.
        req_valid  = 2'b10;
        req_data   = {16'hFFFF, 16'h0000};
        req_be     = {2'b00, 2'b11};
        cnt_before = exp_count;
        base       = grants.size();
        for (int i = 0; i < 10 && grants.size() == base; i++) step();
        check("t4_granted", grants.size(), base + 1);
        req_valid = '0;
        #1;
        check("t4_reg_ena", reg_ena, 2'b00);
        step();
        #1;
        check("t4_wr_done", wr_done, 1);
        check("t4_wr_id", wr_id, 1);
        check("t4_wr_count", wr_count, cnt_before);
        step();

        // Reset while the write is in progress.
        req_valid = 2'b01;
        req_data  = {16'h0000, 16'h5A5A};
        req_be    = 4'b1111;
        step();
        req_valid = '0;
        reset     = 1'b0;
        step();
        reset = 1'b1;
        #1;
        check("t5_no_done", wr_done, 0);
        check("t5_reg_ena", reg_ena, 0);
        req_valid = 2'b11;
        #1;
        check("t5_ptr_restart", req_ready, 2'b01);
        step();
        req_valid = '0;
        step();
        step();

        // Lock: requester 0 holds priority while locking.
        do_reset();
        base      = grants.size();
        req_valid = 2'b11;
        req_be    = 4'b1111;
        for (int i = 0; i < 60 && grants.size() < base + 4; i++) begin
            req_lock = (grants.size() < base + 2) ? 2'b01 : 2'b00;
            step();
        end
`ifdef REG_ARB_LOCK_EN
        exp6 = '{0, 0, 0, 1};
`else
        exp6 = '{0, 1, 0, 1};
`endif
        check("t6_grant_count", grants.size(), base + 4);
        if (grants.size() >= base + 4) begin
            for (int i = 0; i < 4; i++) check("t6_grant_order", grants[base+i], exp6[i]);
        end
        req_lock  = '0;
        req_valid = '0;
        step();
        step();

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            reset     = ($urandom_range(0, 63) != 0);
            req_valid = NREQ'($urandom);
            req_data  = {16'($urandom), 16'($urandom)};
            req_be    = 4'($urandom);
            req_lock  = NREQ'($urandom);
            step();
        end
        reset = 1'b1;

        // Counter wrap after 2^CNTW non-empty writes.
        do_reset();
        base = grants.size();
        for (int i = 0; i < 2000 && grants.size() < base + 256; i++) begin
            req_valid = NREQ'($urandom_range(1, 3));
            req_data  = {16'($urandom), 16'($urandom)};
            req_be    = {2'($urandom_range(1, 3)), 2'($urandom_range(1, 3))};
            req_lock  = NREQ'($urandom);
            if (grants.size() == base + 255 && (cyc <= done_cyc)) req_valid = req_valid;
            step();
            if (grants.size() == base + 256) req_valid = '0;
        end
        req_valid = '0;
        check("wrap_writes", grants.size(), base + 256);
        step();
        step();
        step();
        #1;
        check("wrap_count", wr_count, CNTW'(256));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
